// File: rtl/mul_pkg.sv
// Shared types and configuration checks for the pipelined multiplier.
// Covers the operation codes, FSM states and WIDTH/LIMB legality rules.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL  = 2'd0,
        MUL_OP_MADD = 2'd1,
        MUL_OP_MSUB = 2'd2
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PP   = 2'd1,
        ACC  = 2'd2
    } mul_state_t;

    localparam int MUL_MIN_LIMB = 8;

    function automatic bit mul_cfg_legal(input int width, input int limb);
        return (limb >= MUL_MIN_LIMB) && (width >= limb) && ((width % limb) == 0);
    endfunction

endpackage

// File: rtl/mul_pp_array.sv
// PP stage of mul_pipe: operand magnitudes, N*N limb multipliers and their registers.
// The result sign is registered here so the sum stage can apply its fix-up.
module mul_pp_array
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LIMB  = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            load,
    input  logic                            is_signed,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    output logic [(WIDTH/LIMB)*(WIDTH/LIMB)-1:0][2*LIMB-1:0] pp,
    output logic                            neg
);

    localparam int N = WIDTH / LIMB;

    logic [WIDTH-1:0]                 mag_a;
    logic [WIDTH-1:0]                 mag_b;
    logic [N*N-1:0][2*LIMB-1:0]       pp_comb;
    logic                             neg_comb;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        neg_comb = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    always_comb begin
        pp_comb = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp_comb[i*N+j] = {{LIMB{1'b0}}, mag_a[i*LIMB +: LIMB]}
                               * {{LIMB{1'b0}}, mag_b[j*LIMB +: LIMB]};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pp  <= '0;
            neg <= 1'b0;
        end else if (load) begin
            pp  <= pp_comb;
            neg <= neg_comb;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined limb-split multiplier with valid/ready accept, done pulse and flush.
// Defining MUL_PIPE_ACC_EN adds the ACC stage for MADD/MSUB; otherwise they act as MUL.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LIMB  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic                 flush,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);

    localparam int N = WIDTH / LIMB;

    if (!mul_cfg_legal(WIDTH, LIMB)) begin : g_bad_cfg
        $error("mul_pipe: WIDTH must be a multiple of LIMB and LIMB must be at least 8");
    end

    mul_state_t                  state;
    mul_state_t                  state_next;
    logic                        accept;
    logic [N*N-1:0][2*LIMB-1:0]  pp;
    logic                        neg;
    logic [2*WIDTH-1:0]          sum;
    logic [2*WIDTH-1:0]          product;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    mul_pp_array #(
        .WIDTH (WIDTH),
        .LIMB  (LIMB)
    ) u_pp_array (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .pp        (pp),
        .neg       (neg)
    );

    // Each partial product lands at its limb-pair offset; the sum is the magnitude.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = sum + ({{(2*WIDTH-2*LIMB){1'b0}}, pp[i*N+j]} << ((i + j) * LIMB));
            end
        end
        product = neg ? (~sum + 1'b1) : sum;
    end

`ifdef MUL_PIPE_ACC_EN
    logic                acc_op_q;
    logic                sub_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [2*WIDTH-1:0]  prod_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_op_q <= 1'b0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
        end else begin
            if (accept) begin
                acc_op_q <= (op == MUL_OP_MADD) || (op == MUL_OP_MSUB);
                sub_q    <= (op == MUL_OP_MSUB);
                acc_q    <= acc;
            end
            if (state == PP && acc_op_q && !flush) begin
                prod_q <= product;
            end
        end
    end
`else
    logic unused_acc_inputs;
    assign unused_acc_inputs = ^{op, acc};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = PP;
`ifdef MUL_PIPE_ACC_EN
            PP:   state_next = acc_op_q ? ACC : IDLE;
`else
            PP:   state_next = IDLE;
`endif
            ACC:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // done defaults low every cycle, so a flush also kills a pulse that was due.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
`ifdef MUL_PIPE_ACC_EN
                if (state == PP && !acc_op_q) begin
                    c    <= product;
                    done <= 1'b1;
                end
                if (state == ACC) begin
                    c    <= sub_q ? (acc_q - prod_q) : (acc_q + prod_q);
                    done <= 1'b1;
                end
`else
                if (state == PP) begin
                    c    <= product;
                    done <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed self-checking bench for mul_pipe with hand-computed expected results.
// Expectations for MADD/MSUB follow whether MUL_PIPE_ACC_EN is defined.
module tb_mul_pipe;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic        flush;
    logic        done;
    logic [63:0] c;

    int checks;
    int fails;

    mul_pipe #(
        .WIDTH (32),
        .LIMB  (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .flush     (flush),
        .done      (done),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Presents one request for one edge, then drops in_valid.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                                 input logic [1:0] top, input logic [63:0] tacc);
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        op        = top;
        acc       = tacc;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Leaves the bench in the done cycle so a back-to-back accept can follow.
    task automatic runOp(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [1:0] top, input logic [63:0] tacc,
                         input logic [63:0] exp_c, input int lat);
        applyStimulus(ta, tb_v, ts, top, tacc);
        for (int k = 1; k < lat; k++) begin
            checkOutput({tag, "_busy_done"}, {63'd0, done}, 64'd0);
            tick();
        end
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_c"}, c, exp_c);
        checkOutput({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        op        = 2'd0;
        a         = '0;
        b         = '0;
        acc       = '0;
        flush     = 1'b0;
        tick();
        tick();
        checkOutput("reset_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_c", c, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        runOp("umul_ff_x2", 32'hFFFF_FFFF, 32'd2, 1'b0, 2'd0, 64'd0, 64'h0000_0001_FFFF_FFFE, 2);
        tick();
        checkOutput("umul_done_one_cycle", {63'd0, done}, 64'd0);
        checkOutput("umul_c_held", c, 64'h0000_0001_FFFF_FFFE);

        runOp("smul_m1_x2", 32'hFFFF_FFFF, 32'd2, 1'b1, 2'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        runOp("smul_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 2'd0, 64'd0, 64'h4000_0000_0000_0000, 2);
        runOp("smul_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2'd0, 64'd0, 64'hC000_0000_8000_0000, 2);
        runOp("umul_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'd0, 64'd0, 64'hFFFF_FFFE_0000_0001, 2);
        runOp("smul_m5_x7", 32'hFFFF_FFFB, 32'd7, 1'b1, 2'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFDD, 2);
        runOp("umul_limbs", 32'h0001_0001, 32'h0001_0001, 1'b0, 2'd3, 64'd0, 64'h0000_0001_0002_0001, 2);
        tick();

        // Flush one cycle after accept: no done, c untouched, ready again.
        applyStimulus(32'd9, 32'd9, 1'b0, 2'd0, 64'd0);
        checkOutput("flush_busy", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_no_done", {63'd0, done}, 64'd0);
        checkOutput("flush_c_held", c, 64'h0000_0001_0002_0001);
        checkOutput("flush_ready", {63'd0, in_ready}, 64'd1);
        tick();
        checkOutput("flush_no_late_done", {63'd0, done}, 64'd0);

        // flush together with in_valid: request must be dropped.
        a        = 32'd5;
        b        = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_valid_ready", {63'd0, in_ready}, 64'd1);
        tick();
        checkOutput("flush_valid_no_done", {63'd0, done}, 64'd0);
        checkOutput("flush_valid_c", c, 64'h0000_0001_0002_0001);

        // Back-to-back: second accept lands in the first op's done cycle.
        runOp("b2b_first", 32'd6, 32'd7, 1'b0, 2'd0, 64'd0, 64'd42, 2);
        runOp("b2b_second", 32'd100, 32'd3, 1'b0, 2'd0, 64'd0, 64'd300, 2);
        tick();

`ifdef MUL_PIPE_ACC_EN
        runOp("madd", 32'd3, 32'd4, 1'b0, 2'd1, 64'h10, 64'h1C, 3);
        runOp("msub", 32'd1, 32'd1, 1'b0, 2'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        runOp("madd_signed", 32'hFFFF_FFFF, 32'd5, 1'b1, 2'd1, 64'd100, 64'd95, 3);
`else
        runOp("madd_as_mul", 32'd3, 32'd4, 1'b0, 2'd1, 64'h10, 64'hC, 2);
        runOp("msub_as_mul", 32'd1, 32'd1, 1'b0, 2'd2, 64'd0, 64'd1, 2);
`endif
        tick();

        // Reset in the middle of PP discards the op.
        applyStimulus(32'd11, 32'd11, 1'b0, 2'd0, 64'd0);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_done", {63'd0, done}, 64'd0);
        checkOutput("midreset_c", c, 64'd0);
        checkOutput("midreset_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        checkOutput("postreset_no_done_1", {63'd0, done}, 64'd0);
        tick();
        checkOutput("postreset_no_done_2", {63'd0, done}, 64'd0);
        checkOutput("postreset_c", c, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, pipelined integer multiplier for the execute stage. Replaces the fixed 32×32 unsigned unit with a configurable-width, limb-split datapath. Supports signed/unsigned operands, a valid/ready request handshake, a one-cycle completion pulse, and pipeline flush. Optional multiply-accumulate for MADD/MSUB is compiled in by macro.

## Interface
- WIDTH, 32: operand width; multiple of LIMB.
- LIMB, 16: limb width for partial products; ≥ 8.
- clk  in  1  clock, rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high only in IDLE.
- is_signed  in  1  1: two's-complement operands; 0: unsigned.
- op  in  2  mul_op_t: MUL=0, MADD=1, MSUB=2; 3 reserved, treated as MUL.
- a, b  in  WIDTH  operands.
- acc  in  2*WIDTH  accumulator {hi,lo}; sampled at accept; used only for MADD/MSUB.
- flush  in  1  abort any in-flight operation.
- done  out  1  one-cycle pulse: result valid this cycle.
- c  out  2*WIDTH  result; held until the next result is written.

## Operation
- Accept: in_valid & in_ready & ~flush. All inputs are sampled on that edge.
- States: IDLE, PP, ACC (ACC exists only with macro).
- IDLE → PP on accept.
- PP → IDLE after one cycle; PP → ACC instead when op is MADD/MSUB and the macro is on.
- ACC → IDLE after one cycle.
- Stage PP register:
  - |a|, |b| magnitudes as WIDTH-bit unsigned (|−2^(WIDTH−1)| fits).
  - N = WIDTH/LIMB; N² partial products of 2*LIMB bits each.
  - neg = is_signed & (a[MSB] ^ b[MSB]).
- Sum: shift partial product (i,j) left by (i+j)*LIMB and add all into 2*WIDTH bits. If neg, negate. Result is exact modulo 2^(2*WIDTH).
- ACC (macro on): c = acc + product for MADD; c = acc − product for MSUB; modulo 2^(2*WIDTH).
- Completion: the final stage writes c and sets done for exactly one cycle.
- flush, any state: next state is IDLE. No write to c. done is cleared the next cycle, including a done already pending for that cycle.
- flush with in_valid in the same cycle: flush wins and the request is not accepted.
- Reset values: state IDLE, in_ready 1, done 0, c 0, all pipeline registers 0. Reset mid-operation discards the operation with no done.

## Timing
- Accept at edge E0.
- MUL latency: c written and done=1 in the cycle after edge E1 (2 edges).
- MADD/MSUB latency (macro on): done in the cycle after E2 (3 edges).
- in_ready is high in the done cycle, so a back-to-back accept is legal.
- Throughput: one MUL per 2 cycles; one MADD/MSUB per 3 cycles.
- Between done pulses, c is stable. done never asserts two cycles in a row.

## Configuration
- MUL_PIPE_ACC_EN defined: ACC state and accumulate datapath are present, and acc is honoured.
- MUL_PIPE_ACC_EN undefined:
  - MADD/MSUB behave as MUL (latency 2).
  - acc is ignored and no ACC state or adder is synthesised.

## Structure
- Shared package mul_pkg holds:
  - mul_op_t enum (MUL_OP_MUL, MUL_OP_MADD, MUL_OP_MSUB).
  - mul_state_t enum (IDLE, PP, ACC).
  - WIDTH/LIMB legality constants.
- Sub-module mul_pp_array: magnitude conversion, the N² limb multipliers, and the PP-stage registers. Parent holds the FSM, shift-add tree, sign fix-up, ACC stage and output register.

## Test plan
- Reset: assert resetn=0 mid-PP → done=0, c=0, in_ready=1; no done after release.
- Unsigned MUL, a=0xFFFFFFFF, b=2 → done in the second cycle after accept, c=0x00000001_FFFFFFFE.
- Signed MUL, a=0xFFFFFFFF, b=2 → c=0xFFFFFFFF_FFFFFFFE. Signed 0x80000000×0x80000000 → c=0x40000000_00000000.
- Back-to-back: accept in the done cycle of the previous op → in_ready=1 and both results correct. done pulses are 2 cycles apart and never adjacent.
- Flush: flush one cycle after accept → no done, c keeps its old value, in_ready=1 next cycle. flush together with in_valid → not accepted.
- MUL_PIPE_ACC_EN on:
  - MADD, acc=0x10, a=3, b=4 → c=0x1C at latency 3.
  - MSUB, acc=0, a=1, b=1 → c=0xFFFFFFFF_FFFFFFFF.
- MUL_PIPE_ACC_EN off: the same MADD → c=0xC at latency 2.
